// File: rtl/uart_pkg.sv
// Purpose : shared UART definitions (RX FSM states, line idle level, default frame geometry).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: rx_state_e, UART_IDLE_LEVEL, UART_DATA_BITS, UART_CLKS_PER_BIT, half_bit_cnt().
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  localparam logic UART_IDLE_LEVEL   = 1'b1;
  localparam int   UART_DATA_BITS    = 8;
  localparam int   UART_CLKS_PER_BIT = 16;

  // Counter value at which the middle of the start bit is reached.
  function automatic int half_bit_cnt(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Purpose : two-flop synchronizer bringing the async serial line into the clk domain.
// Latency : 2 clk cycles from pin to q.
// Backpressure: none; free-running.
// Ports   : clk, rst_n (sync, active-low), d (async line), q (synchronized line, resets idle-high).
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Reset to the idle level so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= UART_IDLE_LEVEL;
      sync_q <= UART_IDLE_LEVEL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// Purpose : UART 8N1 receiver; samples mid-bit, rebuilds LSB-first data, flags framing/overrun.
// Latency : good stop-bit sample -> rx_valid on the next edge (~2 + (CPB-1)/2 + (DATA_BITS+1)*CPB from start edge).
// Backpressure: rx_valid held until rx_ready; a new byte arriving while held overwrites it and pulses rx_overrun.
// Ports   : clk, rst_n (sync, active-low), rx_serial (async, idle high), rx_data/rx_valid/rx_ready
//           (consumer handshake), rx_busy (not IDLE), rx_frame_err / rx_overrun (1-cycle pulses).
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID     = CW'(half_bit_cnt(CLKS_PER_BIT));
  localparam logic [BW-1:0] IDX_LAST    = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_serial),
    .q     (rx_s)
  );

  // Shift register with the current sample dropped into its bit slot.
  always_comb begin
    shift_d            = shift_q;
    shift_d[bit_idx_q] = rx_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      // Consume; a byte completing this same cycle re-sets valid below.
      if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (rx_s != UART_IDLE_LEVEL) begin
            state_q <= START;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end

        START: begin
          if (cnt_q == CNT_MID) begin
            cnt_q <= '0;
            if (rx_s != UART_IDLE_LEVEL) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        DATA: begin
          if (cnt_q == CNT_BIT_END) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            if (bit_idx_q == IDX_LAST) begin
              bit_idx_q <= '0;
              state_q   <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + BW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        STOP: begin
          if (cnt_q == CNT_BIT_END) begin
            cnt_q <= '0;
            if (rx_s == UART_IDLE_LEVEL) begin
              data_q    <= shift_q;
              valid_q   <= 1'b1;
              // Previous byte still held and not taken this cycle -> it is lost.
              overrun_q <= valid_q && !rx_ready;
              state_q   <= IDLE;
              busy_q    <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        BREAK: begin
          // Stay here while the line is held low so a break is not seen as a new start.
          if (rx_s == UART_IDLE_LEVEL) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_busy      = busy_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Purpose : directed self-checking bench for uart_rx_deserializer (CLKS_PER_BIT=16, DATA_BITS=8).
// Latency : frames take 160 clk cycles on the pin; accepted bytes are matched against a queue.
// Backpressure: rx_ready driven per scenario to exercise hold, overrun and same-cycle consume.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_overrun;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  int   vld_cycles = 0;
  int   ferr_cnt   = 0;
  int   ovr_cnt    = 0;
  logic busy_seen  = 1'b0;

  int v0, f0, o0;

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_serial    (rx_serial),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Call just after a rising edge; leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_serial = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_serial = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL unexpected_accept: observed 0x%0h expected no byte", rx_data);
        end else begin
          check("accept_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
      if (rx_valid)     vld_cycles++;
      if (rx_frame_err) ferr_cnt++;
      if (rx_overrun)   ovr_cnt++;
      if (rx_busy)      busy_seen = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    rx_serial = 1'b1;
    rx_ready  = 1'b0;
    wait_cycles(3);

    // Reset state
    check("reset_data",  32'(rx_data),      0);
    check("reset_valid", 32'(rx_valid),     0);
    check("reset_busy",  32'(rx_busy),      0);
    check("reset_ferr",  32'(rx_frame_err), 0);
    check("reset_ovr",   32'(rx_overrun),   0);
    rst_n = 1'b1;
    wait_cycles(5);

    // 1: plain 0xA5 with consumer always ready
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    v0 = vld_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 1'b1);
    wait_cycles(10);
    check("t1_queue_empty", 32'(exp_q.size()), 0);
    check("t1_data",        32'(rx_data),      'hA5);
    check("t1_valid_cycles", 32'(vld_cycles - v0), 1);
    check("t1_no_ferr",     32'(ferr_cnt - f0), 0);
    check("t1_no_ovr",      32'(ovr_cnt - o0),  0);

    // 2: 5-cycle low glitch on an idle line
    busy_seen = 1'b0;
    v0 = vld_cycles; f0 = ferr_cnt;
    rx_serial = 1'b0;
    wait_cycles(5);
    rx_serial = 1'b1;
    wait_cycles(20);
    check("t2_busy_pulsed", 32'(busy_seen), 1);
    check("t2_busy_idle",   32'(rx_busy),   0);
    check("t2_no_valid",    32'(vld_cycles - v0), 0);
    check("t2_no_ferr",     32'(ferr_cnt - f0),   0);

    // 3: bad stop bit followed by a held-low break, then a good frame
    v0 = vld_cycles; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    wait_cycles(40);
    check("t3_busy_in_break", 32'(rx_busy), 1);
    check("t3_ferr_once",     32'(ferr_cnt - f0),   1);
    check("t3_no_valid",      32'(vld_cycles - v0), 0);
    check("t3_data_kept",     32'(rx_data), 'hA5);
    rx_serial = 1'b1;
    wait_cycles(10);
    check("t3_busy_released", 32'(rx_busy), 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_cycles(10);
    check("t3_queue_empty", 32'(exp_q.size()), 0);
    check("t3_data_81",     32'(rx_data), 'h81);
    check("t3_ferr_total",  32'(ferr_cnt - f0), 1);

    // 4: overrun with consumer stalled
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    check("t4_first_pending", 32'(rx_data), 'h11);
    send_frame(8'h22, 1'b1);
    check("t4_data_22",   32'(rx_data),  'h22);
    check("t4_valid_held", 32'(rx_valid), 1);
    check("t4_ovr_pulse", 32'(ovr_cnt - o0), 1);
    rx_ready = 1'b1;
    wait_cycles(1);
    check("t4_valid_drop", 32'(rx_valid), 0);
    check("t4_queue_empty", 32'(exp_q.size()), 0);

    // 5: consume 0x44 in exactly the cycle 0x55 completes
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    send_frame(8'h44, 1'b1);
    check("t5_44_pending", 32'(rx_data),  'h44);
    check("t5_44_valid",   32'(rx_valid), 1);
    fork
      send_frame(8'h55, 1'b1);
      begin
        // Stop bit of this frame is sampled on the 155th edge after the start drive.
        repeat (154) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    check("t5_data_55",   32'(rx_data),  'h55);
    check("t5_valid",     32'(rx_valid), 1);
    check("t5_no_ovr",    32'(ovr_cnt - o0), 0);
    check("t5_44_taken",  32'(exp_q.size()), 1);
    rx_ready = 1'b1;
    wait_cycles(3);
    check("t5_queue_empty", 32'(exp_q.size()), 0);
    check("t5_valid_clear", 32'(rx_valid), 0);

    // 6: reset after bit 3 of 0xFF, then a clean 0x0F
    rx_serial = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_serial = 1'b1;
      wait_cycles(CPB);
    end
    check("t6_busy_midframe", 32'(rx_busy), 1);
    rst_n = 1'b0;
    wait_cycles(1);
    check("t6_rst_data",  32'(rx_data),      0);
    check("t6_rst_valid", 32'(rx_valid),     0);
    check("t6_rst_busy",  32'(rx_busy),      0);
    check("t6_rst_ferr",  32'(rx_frame_err), 0);
    check("t6_rst_ovr",   32'(rx_overrun),   0);
    rst_n = 1'b1;
    v0 = vld_cycles; f0 = ferr_cnt;
    wait_cycles(200);
    check("t6_no_partial_valid", 32'(vld_cycles - v0), 0);
    check("t6_no_partial_ferr",  32'(ferr_cnt - f0),   0);
    check("t6_idle",             32'(rx_busy),         0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    wait_cycles(10);
    check("t6_queue_empty", 32'(exp_q.size()), 0);
    check("t6_data_0F",     32'(rx_data), 'h0F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
